// File: rtl/tetris_gravity_if.sv
// Engine-facing signal bundle for the gravity/level/score controller.
// The master side is the game engine and the slave side is the controller.
interface tetris_gravity_if #(
  parameter int unsigned NUM_ROWS = 20,
  parameter int unsigned SCORE_W  = 20
);
  logic                reset_game;
  logic                any_input;
  logic                move_down;
  logic                drop;
  logic                fallen;
  logic                lines_valid;
  logic [NUM_ROWS-1:0] lines_cleared;
  logic                game_over;
  logic                fall_tick;
  logic                dropping;
  logic                running;
  logic [3:0]          level;
  logic [15:0]         lines_total;
  logic [SCORE_W-1:0]  score;

  modport master (
    output reset_game, any_input, move_down, drop, fallen, lines_valid, lines_cleared, game_over,
    input  fall_tick, dropping, running, level, lines_total, score
  );

  modport slave (
    input  reset_game, any_input, move_down, drop, fallen, lines_valid, lines_cleared, game_over,
    output fall_tick, dropping, running, level, lines_total, score
  );
endinterface

// File: rtl/tetris_gravity_ctrl.sv
// Gravity, level and score controller: level-dependent fall strobe with soft/hard drop,
// plus saturating line, level and score accounting.
module tetris_gravity_ctrl #(
  parameter int unsigned PERIOD_W        = 24,
  parameter int unsigned BASE_PERIOD     = 16777215,
  parameter int unsigned PERIOD_STEP     = 1048576,
  parameter int unsigned MIN_PERIOD      = 1048576,
  parameter int unsigned NUM_ROWS        = 20,
  parameter int unsigned LINES_PER_LEVEL = 10,
  parameter int unsigned MAX_LEVEL       = 15,
  parameter int unsigned SCORE_W         = 20
) (
  input logic             clk,
  input logic             reset_n,
  tetris_gravity_if.slave bus
);
  localparam int unsigned PW = PERIOD_W + 4;
  localparam logic [32:0] ScoreMax = (33'd1 << SCORE_W) - 33'd1;

  typedef enum logic [1:0] {StIdle, StRun, StDrop, StOver} state_e;

  state_e              state_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic                fall_tick_q;
  logic                dropping_q;
  logic [3:0]          level_q;
  logic [15:0]         lines_total_q;
  logic [15:0]         lil_q;
  logic [SCORE_W-1:0]  score_q;

  logic [7:0]         pop;
  logic [2:0]         n;
  logic [PW-1:0]      period_sub, period_raw, period;
  logic               timeout;
  logic [10:0]        base_pts;
  logic [32:0]        score_sum;
  logic [SCORE_W-1:0] score_next;
  logic [16:0]        total_sum;
  logic [15:0]        total_next;
  logic [15:0]        lil_sum, lil_next;
  logic               level_up;
  logic [3:0]         level_next;
  logic               lines_ok;

  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(NUM_ROWS); i++) pop = pop + 8'(bus.lines_cleared[i]);
    n = (pop > 8'd4) ? 3'd4 : pop[2:0];

    // Period never underflows: subtract only when the base exceeds the reduction.
    period_sub = PW'(level_q) * PW'(PERIOD_STEP);
    period_raw = (PW'(BASE_PERIOD) > period_sub) ? PW'(BASE_PERIOD) - period_sub : '0;
    period     = (period_raw < PW'(MIN_PERIOD)) ? PW'(MIN_PERIOD) : period_raw;
    timeout    = PW'(cnt_q) >= (period - PW'(1));

    unique case (n)
      3'd1:    base_pts = 11'd40;
      3'd2:    base_pts = 11'd100;
      3'd3:    base_pts = 11'd300;
      3'd4:    base_pts = 11'd1200;
      default: base_pts = 11'd0;
    endcase
    score_sum  = 33'(score_q) + 33'(32'(base_pts) * (32'(level_q) + 32'd1));
    score_next = (score_sum > ScoreMax) ? SCORE_W'(ScoreMax) : SCORE_W'(score_sum);

    total_sum  = 17'(lines_total_q) + 17'(n);
    total_next = total_sum[16] ? 16'hFFFF : total_sum[15:0];

    lil_sum    = lil_q + 16'(n);
    level_up   = lil_sum >= 16'(LINES_PER_LEVEL);
    lil_next   = level_up ? lil_sum - 16'(LINES_PER_LEVEL) : lil_sum;
    level_next = (level_up && level_q < 4'(MAX_LEVEL)) ? level_q + 4'd1 : level_q;

    lines_ok = bus.lines_valid && n != 3'd0 && (state_q == StRun || state_q == StDrop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      fall_tick_q   <= 1'b0;
      dropping_q    <= 1'b0;
      level_q       <= '0;
      lines_total_q <= '0;
      lil_q         <= '0;
      score_q       <= '0;
    end else if (bus.reset_game) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      fall_tick_q   <= 1'b0;
      dropping_q    <= 1'b0;
      level_q       <= '0;
      lines_total_q <= '0;
      lil_q         <= '0;
      score_q       <= '0;
    end else if (bus.game_over) begin
      state_q     <= StOver;
      fall_tick_q <= 1'b0;
      dropping_q  <= 1'b0;
    end else begin
      fall_tick_q <= 1'b0;
      if (lines_ok) begin
        lines_total_q <= total_next;
        lil_q         <= lil_next;
        level_q       <= level_next;
        score_q       <= score_next;
      end
      unique case (state_q)
        StIdle: begin
          if (bus.any_input || bus.move_down || bus.drop) begin
            cnt_q <= '0;
            if (bus.drop) begin
              state_q     <= StDrop;
              fall_tick_q <= 1'b1;
              dropping_q  <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (bus.drop) begin
            state_q     <= StDrop;
            fall_tick_q <= 1'b1;
            dropping_q  <= 1'b1;
          end else if (bus.move_down || timeout) begin
            cnt_q       <= '0;
            fall_tick_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + PERIOD_W'(1);
          end
        end
        StDrop: begin
          if (bus.fallen) begin
            state_q    <= StRun;
            cnt_q      <= '0;
            dropping_q <= 1'b0;
          end else begin
            fall_tick_q <= 1'b1;
          end
        end
        StOver: ;
      endcase
    end
  end

  assign bus.fall_tick   = fall_tick_q;
  assign bus.dropping    = dropping_q;
  assign bus.running     = (state_q == StRun) || (state_q == StDrop);
  assign bus.level       = level_q;
  assign bus.lines_total = lines_total_q;
  assign bus.score       = score_q;
endmodule

// File: tb/tb_tetris_gravity_ctrl.sv
// Bench for tetris_gravity_ctrl: directed scenarios followed by randomized play, every cycle
// compared against a behavioural game model.
module tb_tetris_gravity_ctrl;
  localparam int BASE  = 100;
  localparam int STEP  = 10;
  localparam int MINP  = 20;
  localparam int LPL   = 2;
  localparam int MAXL  = 15;
  localparam int ROWS  = 20;
  localparam int SW    = 20;
  localparam longint SMAX = (64'd1 << SW) - 1;

  localparam int MIdle = 0, MRun = 1, MDrop = 2, MOver = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  tetris_gravity_if #(.NUM_ROWS(ROWS), .SCORE_W(SW)) bus ();

  tetris_gravity_ctrl #(
    .PERIOD_W(24), .BASE_PERIOD(BASE), .PERIOD_STEP(STEP), .MIN_PERIOD(MINP),
    .NUM_ROWS(ROWS), .LINES_PER_LEVEL(LPL), .MAX_LEVEL(MAXL), .SCORE_W(SW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference game model
  int     m_mode, m_since, m_level, m_lil;
  bit     m_tick, m_drop;
  longint m_total, m_score;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int points(input int n);
    case (n)
      1: return 40;
      2: return 100;
      3: return 300;
      4: return 1200;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = MIdle; m_since = 0; m_level = 0; m_lil = 0;
    m_tick = 0; m_drop = 0; m_total = 0; m_score = 0;
  endtask

  task automatic model_step(input bit ai, md, dr, fa, lv, input logic [ROWS-1:0] lc,
                            input bit go, rg);
    int n, per;
    if (rg) begin
      model_reset();
      return;
    end
    if (go) begin
      m_mode = MOver; m_tick = 0; m_drop = 0;
      return;
    end
    per = BASE - m_level * STEP;
    if (per < MINP) per = MINP;
    if (lv && (m_mode == MRun || m_mode == MDrop)) begin
      n = $countones(lc);
      if (n > 4) n = 4;
      if (n > 0) begin
        m_score += points(n) * (m_level + 1);
        if (m_score > SMAX) m_score = SMAX;
        m_total += n;
        if (m_total > 65535) m_total = 65535;
        m_lil += n;
        if (m_lil >= LPL) begin
          m_lil -= LPL;
          if (m_level < MAXL) m_level++;
        end
      end
    end
    m_tick = 0;
    case (m_mode)
      MIdle: if (ai || md || dr) begin
        m_since = 0;
        if (dr) begin m_mode = MDrop; m_tick = 1; m_drop = 1; end
        else m_mode = MRun;
      end
      MRun: begin
        if (dr) begin m_mode = MDrop; m_tick = 1; m_drop = 1; end
        else if (md || m_since + 1 >= per) begin m_since = 0; m_tick = 1; end
        else m_since++;
      end
      MDrop: begin
        if (fa) begin m_mode = MRun; m_since = 0; m_drop = 0; end
        else m_tick = 1;
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    check_eq("fall_tick", 32'(bus.fall_tick), 32'(m_tick));
    check_eq("dropping", 32'(bus.dropping), 32'(m_drop));
    check_eq("running", 32'(bus.running), 32'(m_mode == MRun || m_mode == MDrop));
    check_eq("level", 32'(bus.level), 32'(m_level));
    check_eq("lines_total", 32'(bus.lines_total), 32'(m_total));
    check_eq("score", 32'(bus.score), 32'(m_score));
  endtask

  task automatic cycle(input bit ai, md, dr, fa, lv, input logic [ROWS-1:0] lc,
                       input bit go, rg);
    bus.any_input = ai; bus.move_down = md; bus.drop = dr; bus.fallen = fa;
    bus.lines_valid = lv; bus.lines_cleared = lc; bus.game_over = go; bus.reset_game = rg;
    @(posedge clk);
    cyc++;
    model_step(ai, md, dr, fa, lv, lc, go, rg);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic lines(input logic [ROWS-1:0] lc);
    cycle(0, 0, 0, 0, 1, lc, 0, 0);
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int waited;
    bus.any_input = 0; bus.move_down = 0; bus.drop = 0; bus.fallen = 0;
    bus.lines_valid = 0; bus.lines_cleared = '0; bus.game_over = 0; bus.reset_game = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset_n = 1'b1;

    idle(20);
    cycle(1, 0, 0, 0, 0, '0, 0, 0);
    idle(210);

    waited = 0;
    while (!bus.fall_tick && waited < 200) begin idle(1); waited++; end
    if (waited >= 200) check_eq("tick_timeout", 32'(bus.fall_tick), 32'd1);
    idle(29);
    cycle(0, 1, 0, 0, 0, '0, 0, 0);
    idle(105);

    cycle(0, 0, 1, 0, 0, '0, 0, 0);
    idle(6);
    cycle(0, 0, 0, 1, 0, '0, 0, 0);
    idle(105);

    lines(20'b1111);
    check_eq("score_first", 32'(bus.score), 32'd1200);
    check_eq("level_first", 32'(bus.level), 32'd1);
    lines(20'b0011);
    check_eq("score_second", 32'(bus.score), 32'd1400);
    check_eq("lines_second", 32'(bus.lines_total), 32'd6);
    check_eq("level_second", 32'(bus.level), 32'd2);
    idle(80);
    for (int i = 0; i < 80; i++) begin
      lines(20'hF00F0 | 20'(i));
      idle(3);
    end
    check_eq("level_sat", 32'(bus.level), 32'(MAXL));
    check_eq("score_sat", 32'(bus.score), 32'(SMAX));
    idle(70);

    cycle(0, 0, 1, 0, 0, '0, 0, 0);
    idle(2);
    cycle(0, 0, 0, 0, 0, '0, 1, 0);
    cycle(0, 0, 0, 0, 1, 20'b111, 1, 0);
    cycle(0, 1, 1, 0, 1, 20'b1, 0, 0);
    idle(5);
    cycle(0, 0, 0, 0, 0, '0, 0, 1);
    idle(5);

    cycle(1, 0, 0, 0, 0, '0, 0, 0);
    idle(40);
    async_reset();
    idle(5);

    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 1999) == 0) async_reset();
      else cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 199) < 2, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 6, ROWS'($urandom() & $urandom()),
                 $urandom_range(0, 999) < 2, $urandom_range(0, 999) < 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
